// File: rtl/multdiv_issue_controller.sv
// Execute-stage issue controller for the multi-cycle multiplier/divider.
// Detects a mul/div in the DX latch and freezes the front of the pipeline.
// Sends one start pulse with held operands to the multdiv unit, then waits
// for its completion strobe or a timeout. For one cycle it hands either the
// result or the $rstatus exception write to the XM latch.
// TIMEOUT must not exceed 62 so that the saturating 6-bit counter can reach it.
module multdiv_issue_controller #(
    parameter int TIMEOUT  = 40,
    parameter int MUL_CODE = 4,
    parameter int DIV_CODE = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  opcode_DX,
    input  logic [4:0]  aluop_DX,
    input  logic [4:0]  rd_DX,
    input  logic [31:0] operandA,
    input  logic [31:0] operandB,
    input  logic [31:0] data_result,
    input  logic        data_exception,
    input  logic        data_resultRDY,
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    output logic [31:0] md_operandA,
    output logic [31:0] md_operandB,
    output logic        stall_multdiv,
    output logic        result_sel,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic [4:0]  busy_rd
);

    localparam logic [4:0]  OPCODE_ALU  = 5'b00000;
    localparam logic [4:0]  ALUOP_MUL   = 5'b00110;
    localparam logic [4:0]  ALUOP_DIV   = 5'b00111;
    localparam logic [4:0]  RSTATUS_REG = 5'd30;
    localparam logic [5:0]  TIMEOUT_CNT = 6'(TIMEOUT);
    localparam logic [5:0]  CNT_MAX     = 6'h3f;
    localparam logic [31:0] MUL_EXC     = 32'(MUL_CODE);
    localparam logic [31:0] DIV_EXC     = 32'(DIV_CODE);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state;
    logic [5:0]  wait_count;
    logic        pulse_pending;
    logic        op_is_div;
    logic [4:0]  captured_rd;

    logic        is_muldiv_dx;
    logic        start;
    logic        rdy_accept;
    logic        timeout_hit;
    logic        finish_exc;
    logic [31:0] finish_result;
    logic [31:0] exc_code;

    // Decode the DX instruction and qualify completion events for this cycle.
    // start is gated by reset so the stall drops the moment reset asserts,
    // even though DX may still hold a mul/div.
    always_comb begin
        is_muldiv_dx  = (opcode_DX == OPCODE_ALU) &&
                        ((aluop_DX == ALUOP_MUL) || (aluop_DX == ALUOP_DIV));
        start         = reset && (state == ST_IDLE) && is_muldiv_dx;
        rdy_accept    = (state == ST_WAIT) && !pulse_pending && data_resultRDY;
        timeout_hit   = (state == ST_WAIT) && (wait_count == TIMEOUT_CNT);
        finish_exc    = rdy_accept ? data_exception : 1'b1;
        finish_result = rdy_accept ? data_result : 32'd0;
        exc_code      = op_is_div ? DIV_EXC : MUL_EXC;
    end

    // The front of the pipeline is frozen while issuing and waiting; DONE
    // lets the mul/div advance into XM.
    assign stall_multdiv = start || (state == ST_WAIT);

    // Issue/wait/writeback sequencer; every output except the stall is registered here.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            wait_count    <= 6'd0;
            pulse_pending <= 1'b0;
            op_is_div     <= 1'b0;
            captured_rd   <= 5'd0;
            ctrl_MULT     <= 1'b0;
            ctrl_DIV      <= 1'b0;
            md_operandA   <= 32'd0;
            md_operandB   <= 32'd0;
            result_sel    <= 1'b0;
            wb_rd         <= 5'd0;
            wb_data       <= 32'd0;
            busy_rd       <= 5'd0;
        end else begin
            ctrl_MULT <= 1'b0;
            ctrl_DIV  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    result_sel <= 1'b0;
                    wb_rd      <= 5'd0;
                    wb_data    <= 32'd0;
                    busy_rd    <= 5'd0;
                    if (start) begin
                        md_operandA   <= operandA;
                        md_operandB   <= operandB;
                        captured_rd   <= rd_DX;
                        busy_rd       <= rd_DX;
                        op_is_div     <= (aluop_DX == ALUOP_DIV);
                        ctrl_MULT     <= (aluop_DX == ALUOP_MUL);
                        ctrl_DIV      <= (aluop_DX == ALUOP_DIV);
                        wait_count    <= 6'd0;
                        pulse_pending <= 1'b1;
                        state         <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    pulse_pending <= 1'b0;
                    if (wait_count != CNT_MAX) begin
                        wait_count <= wait_count + 6'd1;
                    end
                    if (rdy_accept || timeout_hit) begin
                        result_sel <= 1'b1;
                        wb_rd      <= finish_exc ? RSTATUS_REG : captured_rd;
                        wb_data    <= finish_exc ? exc_code : finish_result;
                        state      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    result_sel <= 1'b0;
                    wb_rd      <= 5'd0;
                    wb_data    <= 32'd0;
                    busy_rd    <= 5'd0;
                    state      <= ST_IDLE;
                end
                default: begin
                    result_sel <= 1'b0;
                    wb_rd      <= 5'd0;
                    wb_data    <= 32'd0;
                    busy_rd    <= 5'd0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_issue_controller.sv
// Testbench for multdiv_issue_controller. A behavioural model derives each
// operation's stall length, pulse cycle and writeback from its RDY latency.
module tb_multdiv_issue_controller;

    localparam int TIMEOUT  = 40;
    localparam int MUL_CODE = 4;
    localparam int DIV_CODE = 5;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  opcode_DX;
    logic [4:0]  aluop_DX;
    logic [4:0]  rd_DX;
    logic [31:0] operandA;
    logic [31:0] operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] md_operandA;
    logic [31:0] md_operandB;
    logic        stall_multdiv;
    logic        result_sel;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [4:0]  busy_rd;

    int passed = 0;
    int total  = 0;

    multdiv_issue_controller #(
        .TIMEOUT (TIMEOUT),
        .MUL_CODE(MUL_CODE),
        .DIV_CODE(DIV_CODE)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .opcode_DX     (opcode_DX),
        .aluop_DX      (aluop_DX),
        .rd_DX         (rd_DX),
        .operandA      (operandA),
        .operandB      (operandB),
        .data_result   (data_result),
        .data_exception(data_exception),
        .data_resultRDY(data_resultRDY),
        .ctrl_MULT     (ctrl_MULT),
        .ctrl_DIV      (ctrl_DIV),
        .md_operandA   (md_operandA),
        .md_operandB   (md_operandB),
        .stall_multdiv (stall_multdiv),
        .result_sel    (result_sel),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .busy_rd       (busy_rd)
    );

    always #5 clock = ~clock;

    // Reset asserted with a mul sitting in DX: all outputs must be 0, including the stall.
    task automatic test_reset();
        reset          = 1'b0;
        opcode_DX      = 5'd0;
        aluop_DX       = 5'd6;
        rd_DX          = 5'd9;
        operandA       = 32'h1234;
        operandB       = 32'h5678;
        data_result    = 32'd0;
        data_exception = 1'b0;
        data_resultRDY = 1'b0;
        #2;
        total++;
        if ({ctrl_MULT, ctrl_DIV, stall_multdiv, result_sel} !== 4'b0000) begin
            $display("[TB] FAIL reset_ctrl: got %b expected 0000", {ctrl_MULT, ctrl_DIV, stall_multdiv, result_sel});
        end else passed++;
        total++;
        if ({wb_rd, wb_data, busy_rd, md_operandA, md_operandB} !== '0) begin
            $display("[TB] FAIL reset_data: wb_rd=%0d wb_data=%0d busy_rd=%0d mdA=%0h mdB=%0h expected all 0",
                     wb_rd, wb_data, busy_rd, md_operandA, md_operandB);
        end else passed++;
        aluop_DX = 5'd0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    // One complete mul/div beginning in the next cycle; c counts cycles from T.
    // k is the RDY latency after the pulse cycle (0 = never).
    task automatic run_op(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input int k, input bit exc,
                          input logic [31:0] res, input bit stale,
                          output int stall_cycles, output int mult_pulses,
                          output int div_pulses, output int done_cycle);
        bit          to;
        int          len;
        logic [4:0]  exp_rd;
        logic [31:0] exp_data;
        to = (k < 1) || (k > TIMEOUT);
        len = to ? TIMEOUT + 2 : k + 2;
        if (to || exc) begin
            exp_rd   = 5'd30;
            exp_data = is_div ? 32'(DIV_CODE) : 32'(MUL_CODE);
        end else begin
            exp_rd   = rd;
            exp_data = res;
        end
        stall_cycles = 0;
        mult_pulses  = 0;
        div_pulses   = 0;
        done_cycle   = -1;
        for (int c = 0; c <= len; c++) begin
            @(posedge clock);
            #1;
            if (c == 0) begin
                opcode_DX = 5'd0;
                aluop_DX  = is_div ? 5'd7 : 5'd6;
                rd_DX     = rd;
                operandA  = a;
                operandB  = b;
            end else begin
                operandA = $urandom;
                operandB = $urandom;
            end
            data_resultRDY = (!to && c == k + 1) || (stale && c == 1);
            data_result    = (!to && c == k + 1) ? res : $urandom;
            data_exception = (!to && c == k + 1) ? exc : 1'($urandom_range(0, 1));
            @(negedge clock);
            if (stall_multdiv === 1'b1) stall_cycles++;
            if (ctrl_MULT === 1'b1) mult_pulses++;
            if (ctrl_DIV === 1'b1) div_pulses++;
            if (result_sel === 1'b1 && done_cycle < 0) done_cycle = c;
            total++;
            if (stall_multdiv !== (c < len)) begin
                $display("[TB] FAIL stall c=%0d: got %b expected %b", c, stall_multdiv, (c < len));
            end else passed++;
            total++;
            if ({ctrl_MULT, ctrl_DIV} !== {(c == 1) && !is_div, (c == 1) && is_div}) begin
                $display("[TB] FAIL ctrl_pulse c=%0d: got %b%b expected %b%b", c, ctrl_MULT, ctrl_DIV,
                         (c == 1) && !is_div, (c == 1) && is_div);
            end else passed++;
            total++;
            if (result_sel !== (c == len)) begin
                $display("[TB] FAIL result_sel c=%0d: got %b expected %b", c, result_sel, (c == len));
            end else passed++;
            total++;
            if (wb_rd !== ((c == len) ? exp_rd : 5'd0)) begin
                $display("[TB] FAIL wb_rd c=%0d: got %0d expected %0d", c, wb_rd, (c == len) ? exp_rd : 5'd0);
            end else passed++;
            total++;
            if (wb_data !== ((c == len) ? exp_data : 32'd0)) begin
                $display("[TB] FAIL wb_data c=%0d: got %0h expected %0h", c, wb_data, (c == len) ? exp_data : 32'd0);
            end else passed++;
            total++;
            if (busy_rd !== ((c >= 1) ? rd : 5'd0)) begin
                $display("[TB] FAIL busy_rd c=%0d: got %0d expected %0d", c, busy_rd, (c >= 1) ? rd : 5'd0);
            end else passed++;
            if (c >= 1) begin
                total++;
                if ({md_operandA, md_operandB} !== {a, b}) begin
                    $display("[TB] FAIL md_operands c=%0d: got %0h/%0h expected %0h/%0h", c, md_operandA, md_operandB, a, b);
                end else passed++;
            end
        end
        data_resultRDY = 1'b0;
    endtask

    // A non-mul/div instruction in DX for one cycle: nothing is issued or written.
    task automatic test_idle_cycle(input logic [4:0] op, input logic [4:0] aop);
        @(posedge clock);
        #1;
        opcode_DX      = op;
        aluop_DX       = aop;
        rd_DX          = 5'($urandom);
        data_resultRDY = 1'($urandom_range(0, 1));
        @(negedge clock);
        total++;
        if ({stall_multdiv, ctrl_MULT, ctrl_DIV, result_sel} !== 4'b0000) begin
            $display("[TB] FAIL idle_ctrl op=%0d aluop=%0d: got %b expected 0000", op, aop,
                     {stall_multdiv, ctrl_MULT, ctrl_DIV, result_sel});
        end else passed++;
        total++;
        if ({busy_rd, wb_rd, wb_data} !== '0) begin
            $display("[TB] FAIL idle_data: busy_rd=%0d wb_rd=%0d wb_data=%0h expected 0", busy_rd, wb_rd, wb_data);
        end else passed++;
        data_resultRDY = 1'b0;
    endtask

    // Directed mul 7*6 with RDY 17 cycles after the pulse.
    task automatic test_mul_basic();
        int st, mp, dp, dc;
        run_op(1'b0, 32'd7, 32'd6, 5'd3, 17, 1'b0, 32'd42, 1'b0, st, mp, dp, dc);
        total++;
        if (st !== 19) $display("[TB] FAIL mul_stall_len: got %0d expected 19", st); else passed++;
        total++;
        if (mp !== 1 || dp !== 0) $display("[TB] FAIL mul_pulses: got mult=%0d div=%0d expected 1/0", mp, dp); else passed++;
        test_idle_cycle(5'd0, 5'd0);
    endtask

    // Divide by zero reports through $rstatus.
    task automatic test_div_by_zero();
        int st, mp, dp, dc;
        run_op(1'b1, 32'd9, 32'd0, 5'd4, 6, 1'b1, 32'hdead, 1'b0, st, mp, dp, dc);
        total++;
        if (dp !== 1 || mp !== 0) $display("[TB] FAIL div_pulses: got mult=%0d div=%0d expected 0/1", mp, dp); else passed++;
        test_idle_cycle(5'd0, 5'd0);
    endtask

    // No RDY ever: forced exception at T+TIMEOUT+2.
    task automatic test_timeout();
        int st, mp, dp, dc;
        run_op(1'b0, 32'd11, 32'd13, 5'd8, 0, 1'b0, 32'd0, 1'b0, st, mp, dp, dc);
        total++;
        if (dc !== TIMEOUT + 2) $display("[TB] FAIL timeout_done_cycle: got %0d expected %0d", dc, TIMEOUT + 2); else passed++;
        test_idle_cycle(5'd0, 5'd0);
    endtask

    // Stale strobe in the pulse cycle must be ignored.
    task automatic test_stale_rdy();
        int st, mp, dp, dc;
        run_op(1'b0, 32'd5, 32'd3, 5'd12, 10, 1'b0, 32'd15, 1'b1, st, mp, dp, dc);
        total++;
        if (dc !== 12) $display("[TB] FAIL stale_done_cycle: got %0d expected 12", dc); else passed++;
        test_idle_cycle(5'd0, 5'd0);
    endtask

    // mul then div back to back, then an add.
    task automatic test_back_to_back();
        int st, mp, dp, dc;
        run_op(1'b0, 32'd100, 32'd3, 5'd1, 4, 1'b0, 32'd300, 1'b0, st, mp, dp, dc);
        run_op(1'b1, 32'd100, 32'd3, 5'd2, 7, 1'b0, 32'd33, 1'b0, st, mp, dp, dc);
        total++;
        if (dp !== 1 || mp !== 0) $display("[TB] FAIL b2b_second_pulse: got mult=%0d div=%0d expected 0/1", mp, dp); else passed++;
        test_idle_cycle(5'd0, 5'd0);
    endtask

    // Non-mul/div encodings never start an operation.
    task automatic test_non_muldiv();
        for (int i = 0; i < 12; i++) begin
            if (i % 2 == 0) test_idle_cycle(5'($urandom_range(1, 31)), 5'($urandom_range(6, 7)));
            else test_idle_cycle(5'd0, 5'($urandom_range(0, 5)));
        end
    endtask

    // Reset 5 cycles into WAIT aborts at once; a new mul then issues normally.
    task automatic test_reset_mid_wait();
        int st, mp, dp, dc;
        @(posedge clock);
        #1;
        opcode_DX = 5'd0;
        aluop_DX  = 5'd6;
        rd_DX     = 5'd17;
        operandA  = 32'd21;
        operandB  = 32'd2;
        repeat (6) @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        total++;
        if ({ctrl_MULT, ctrl_DIV, stall_multdiv, result_sel} !== 4'b0000) begin
            $display("[TB] FAIL midreset_ctrl: got %b expected 0000", {ctrl_MULT, ctrl_DIV, stall_multdiv, result_sel});
        end else passed++;
        total++;
        if ({wb_rd, wb_data, busy_rd} !== '0) begin
            $display("[TB] FAIL midreset_data: wb_rd=%0d wb_data=%0h busy_rd=%0d expected 0", wb_rd, wb_data, busy_rd);
        end else passed++;
        aluop_DX = 5'd0;
        @(negedge clock);
        reset = 1'b1;
        run_op(1'b0, 32'd21, 32'd2, 5'd17, 3, 1'b0, 32'd42, 1'b0, st, mp, dp, dc);
        total++;
        if (mp !== 1) $display("[TB] FAIL post_reset_pulse: got %0d expected 1", mp); else passed++;
        test_idle_cycle(5'd0, 5'd0);
    endtask

    // Randomised chain of operations, including timeouts and rd=0.
    task automatic test_random();
        int st, mp, dp, dc;
        for (int i = 0; i < 12; i++) begin
            run_op(1'($urandom_range(0, 1)), $urandom, $urandom, 5'($urandom_range(0, 31)),
                   int'($urandom_range(0, 46)), ($urandom_range(0, 3) == 0), $urandom,
                   1'($urandom_range(0, 1)), st, mp, dp, dc);
            if (i % 3 == 2) test_idle_cycle(5'd0, 5'd0);
        end
        test_idle_cycle(5'd0, 5'd0);
    endtask

    initial begin
        test_reset();
        test_mul_basic();
        test_div_by_zero();
        test_timeout();
        test_stale_rdy();
        test_back_to_back();
        test_non_muldiv();
        test_reset_mid_wait();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/multdiv_issue_controller.md
# multdiv_issue_controller

Execute-stage initiator for the multi-cycle multiplier/divider. It detects a `mul`/`div` in the DX latch and freezes the front of the pipeline. It issues a single-cycle start pulse with held operands to the multdiv unit, then waits for `data_resultRDY` or a timeout. On completion it hands the result, or the `$rstatus` exception write, to the XM latch for normal bypass and writeback.

## Interface
Parameters:
- `TIMEOUT`, default 40: maximum WAIT cycles after the start pulse before forced completion.
- `MUL_CODE`, default 4: `$rstatus` value written on a mul exception or timeout.
- `DIV_CODE`, default 5: `$rstatus` value written on a div exception or timeout.

Ports:
- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state.
- `opcode_DX`  in  5  DX opcode; `00000` means ALU-type.
- `aluop_DX`  in  5  DX ALU op; `00110` means mul, `00111` means div.
- `rd_DX`  in  5  DX destination register.
- `operandA`, `operandB`  in  32 each  bypassed X-stage operands.
- `data_result`  in  32  multdiv result.
- `data_exception`  in  1  multdiv overflow or divide-by-zero flag.
- `data_resultRDY`  in  1  multdiv completion strobe.
- `ctrl_MULT`, `ctrl_DIV`  out  1 each  one-cycle start pulses.
- `md_operandA`, `md_operandB`  out  32 each  registered operands; held for the whole operation.
- `stall_multdiv`  out  1  freezes PC, FD and DX latches.
- `result_sel`  out  1  XM latch takes `wb_rd`/`wb_data` instead of ALU output.
- `wb_rd`  out  5  destination to write into the XM latch.
- `wb_data`  out  32  value to write into the XM latch.
- `busy_rd`  out  5  destination of the in-flight op; 0 when IDLE.

## Operation
- States:
  - IDLE (reset state).
  - WAIT.
  - DONE.
- Start condition: `start = (state==IDLE) & opcode_DX==0 & (aluop_DX==6 | aluop_DX==7)`.
- IDLE, on `start`:
  - Capture `operandA`/`operandB` into `md_operand*`, and capture `rd_DX` and the op type (mul or div).
  - Go to WAIT.
  - Clear the 6-bit wait counter.
  - Set the pulse flag.
- WAIT:
  - The first cycle drives `ctrl_MULT` (mul) or `ctrl_DIV` (div) high for exactly that cycle.
  - The counter increments every WAIT cycle.
  - `data_resultRDY` is ignored in the pulse cycle (clears stale strobes) and accepted in any later WAIT cycle.
- On an accepted RDY:
  - Register `data_result` and `data_exception`.
  - Go to DONE.
- On counter == `TIMEOUT` without RDY: go to DONE with the exception flag forced to 1 and the result forced to 0.
- DONE (exactly one cycle):
  - `result_sel=1`.
  - No exception: `wb_rd` = captured rd, `wb_data` = result.
  - Exception: `wb_rd=30`, `wb_data` = MUL_CODE or DIV_CODE, zero-extended.
  - The DX mul/div advances into XM this cycle.
  - `start` is not evaluated in DONE, so the same instruction is never reissued.
  - Next state is IDLE.
- Output rules:
  - `stall_multdiv = start | (state==WAIT)`, combinational.
  - `busy_rd` = captured rd in WAIT and DONE, 0 otherwise.
  - `wb_rd`, `wb_data` and `result_sel` are 0 outside DONE.
- Captured rd==0 with no exception: `wb_rd=0`, and the pipeline discards the write. An exception still writes r30.
- Back-to-back mul/div: the second is seen in DX the cycle after DONE, so there is one IDLE cycle between operations.

## Timing
- Reset values: state IDLE, counter 0, and every output 0.
- A reset edge mid-operation aborts immediately:
  - `ctrl_*`, `stall_multdiv` and `result_sel` drop asynchronously.
  - No writeback occurs.
  - The multdiv unit is restarted by the next start pulse.
- Cycle T (IDLE, `start`=1): `stall_multdiv=1`.
- Cycle T+1: WAIT, `ctrl_*`=1, `md_operand*` valid and stable until DONE ends.
- First accepted RDY at cycle T+1+k (k ≥ 1): DONE at T+2+k, with `stall_multdiv=0` and `result_sel=1`.
- Stall length: k+2 cycles. Timeout: DONE at T+2+`TIMEOUT`.
- The counter saturates and never wraps.
- `TIMEOUT` must be ≤ 62.

## Test plan
- **mul without exception:**
  - Stimulus: mul in DX with A=7, B=6, rd=3; RDY at pulse+17 with result 42.
  - Required: `ctrl_MULT` high exactly 1 cycle; stall 19 cycles; DONE gives `wb_rd=3`, `wb_data=42`.
- **div by zero:**
  - Stimulus: div with A=9, B=0, rd=4; RDY with `data_exception=1`.
  - Required: `ctrl_DIV` pulses; DONE gives `wb_rd=30`, `wb_data=5`.
- **Timeout:**
  - Stimulus: mul issued, RDY never asserted, `TIMEOUT=40`.
  - Required: DONE at T+42 with `wb_rd=30`, `wb_data=4`; next cycle IDLE with stall 0.
- **Stale RDY:**
  - Stimulus: RDY held high in the pulse cycle, low afterwards, real RDY 10 cycles later.
  - Required: the pulse-cycle RDY is ignored; DONE follows the real RDY.
- **Back-to-back and non-mul/div:**
  - Stimulus: DX holds mul then div; separately, add (aluop 0) in DX.
  - Required: two distinct pulses with one IDLE cycle between; the add produces no stall and no pulse.
- **Reset mid-WAIT:**
  - Stimulus: `reset` driven low 5 cycles into WAIT.
  - Required: all outputs 0 immediately; after release, a new mul issues normally.
